// File: rtl/alu_pkg.sv
// Shared encodings and request bundle for the ALU arbiter slice.
package alu_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ALU_DW  = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_JAL  = 4'b1011,
        ALU_JALR = 4'b1100,
        ALU_LW   = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ   = 3'b000,
        BR_BNE   = 3'b001,
        BR_BLT   = 3'b010,
        BR_BGE   = 3'b011,
        BR_BLTU  = 3'b100,
        BR_BGEU  = 3'b101,
        BR_BNONE = 3'b111
    } br_op_e;

    typedef struct packed {
        logic [ALU_DW-1:0] srcA;
        logic [ALU_DW-1:0] srcB;
        alu_op_e           ctrl;
        br_op_e            brctrl;
    } alu_req_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: on a tie the port other than the last grant wins.
module alu_rr_pick
    import alu_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic               last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               idx_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = 1'b0;
        if (elig_i[0] && (!elig_i[1] || last_i)) begin
            gnt_o[0] = 1'b1;
            idx_o    = 1'b0;
        end else if (elig_i[1]) begin
            gnt_o[1] = 1'b1;
            idx_o    = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two requesters; results are held
// in per-port response registers until drained.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned CTRL_WIDTH = 4,
    parameter int unsigned BR_WIDTH   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            ReqValid_i,
    output logic [1:0]            ReqReady_o,
    input  logic [DATAWIDTH-1:0]  SrcA0_i,
    input  logic [DATAWIDTH-1:0]  SrcB0_i,
    input  logic [DATAWIDTH-1:0]  SrcA1_i,
    input  logic [DATAWIDTH-1:0]  SrcB1_i,
    input  logic [CTRL_WIDTH-1:0] ALUctrl0_i,
    input  logic [CTRL_WIDTH-1:0] ALUctrl1_i,
    input  logic [BR_WIDTH-1:0]   BranchCtrl0_i,
    input  logic [BR_WIDTH-1:0]   BranchCtrl1_i,
    output logic [1:0]            RspValid_o,
    input  logic [1:0]            RspReady_i,
    output logic [DATAWIDTH-1:0]  Result0_o,
    output logic [DATAWIDTH-1:0]  Result1_o,
    output logic                  Branch0_o,
    output logic                  Branch1_o,
    output logic [DATAWIDTH-1:0]  AluSrcA_o,
    output logic [DATAWIDTH-1:0]  AluSrcB_o,
    output logic [CTRL_WIDTH-1:0] AluCtrl_o,
    output logic [BR_WIDTH-1:0]   AluBranchCtrl_o,
    input  logic [DATAWIDTH-1:0]  AluResult_i,
    input  logic                  AluBranch_i
);

    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] result_q [NUM_REQ];
    logic [DATAWIDTH-1:0] result_d [NUM_REQ];
    logic [NUM_REQ-1:0]  branch_q, branch_d;
    logic                last_q, last_d;

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_idx;

    // Reset suppresses eligibility so no grant (and no ALU drive) occurs in the reset cycle.
    assign elig = ReqValid_i & (~rsp_valid_q | RspReady_i) & {NUM_REQ{~rst_i}};

    alu_rr_pick u_pick (
        .elig_i (elig),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    assign ReqReady_o = gnt;

    always_comb begin
        AluSrcA_o       = '0;
        AluSrcB_o       = '0;
        AluCtrl_o       = '0;
        AluBranchCtrl_o = '1;
        if (gnt[0]) begin
            AluSrcA_o       = SrcA0_i;
            AluSrcB_o       = SrcB0_i;
            AluCtrl_o       = ALUctrl0_i;
            AluBranchCtrl_o = BranchCtrl0_i;
        end else if (gnt[1]) begin
            AluSrcA_o       = SrcA1_i;
            AluSrcB_o       = SrcB1_i;
            AluCtrl_o       = ALUctrl1_i;
            AluBranchCtrl_o = BranchCtrl1_i;
        end
    end

    // A grant reloads the slot even when it drains in the same cycle.
    always_comb begin
        last_d = (|gnt) ? gnt_idx : last_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rsp_valid_d[k] = gnt[k] | (rsp_valid_q[k] & ~RspReady_i[k]);
            result_d[k]    = gnt[k] ? AluResult_i : result_q[k];
            branch_d[k]    = gnt[k] ? AluBranch_i : branch_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            branch_q    <= '0;
            last_q      <= 1'b1;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                result_q[k] <= '0;
            end
        end else begin
            rsp_valid_q <= rsp_valid_d;
            branch_q    <= branch_d;
            last_q      <= last_d;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                result_q[k] <= result_d[k];
            end
        end
    end

    assign RspValid_o = rsp_valid_q;
    assign Result0_o  = result_q[0];
    assign Result1_o  = result_q[1];
    assign Branch0_o  = branch_q[0];
    assign Branch1_o  = branch_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU in the loop.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  ReqValid_i = '0;
    logic [1:0]  ReqReady_o;
    logic [31:0] SrcA0_i = '0, SrcB0_i = '0, SrcA1_i = '0, SrcB1_i = '0;
    logic [3:0]  ALUctrl0_i = '0, ALUctrl1_i = '0;
    logic [2:0]  BranchCtrl0_i = 3'b111, BranchCtrl1_i = 3'b111;
    logic [1:0]  RspValid_o;
    logic [1:0]  RspReady_i = '0;
    logic [31:0] Result0_o, Result1_o;
    logic        Branch0_o, Branch1_o;
    logic [31:0] AluSrcA_o, AluSrcB_o;
    logic [3:0]  AluCtrl_o;
    logic [2:0]  AluBranchCtrl_o;
    logic [31:0] AluResult_i;
    logic        AluBranch_i;

    int total = 0;
    int bad   = 0;

    logic [1:0]  m_valid;
    logic        m_last;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    alu_arbiter #(.DATAWIDTH(32), .CTRL_WIDTH(4), .BR_WIDTH(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ReqValid_i(ReqValid_i), .ReqReady_o(ReqReady_o),
        .SrcA0_i(SrcA0_i), .SrcB0_i(SrcB0_i), .SrcA1_i(SrcA1_i), .SrcB1_i(SrcB1_i),
        .ALUctrl0_i(ALUctrl0_i), .ALUctrl1_i(ALUctrl1_i),
        .BranchCtrl0_i(BranchCtrl0_i), .BranchCtrl1_i(BranchCtrl1_i),
        .RspValid_o(RspValid_o), .RspReady_i(RspReady_i),
        .Result0_o(Result0_o), .Result1_o(Result1_o),
        .Branch0_o(Branch0_o), .Branch1_o(Branch1_o),
        .AluSrcA_o(AluSrcA_o), .AluSrcB_o(AluSrcB_o),
        .AluCtrl_o(AluCtrl_o), .AluBranchCtrl_o(AluBranchCtrl_o),
        .AluResult_i(AluResult_i), .AluBranch_i(AluBranch_i)
    );

    always #5 clk_i = ~clk_i;

    // Returns {branch, result}.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c, input logic [2:0] br);
        logic [31:0] r;
        logic        f;
        case (c)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            default: r = '0;
        endcase
        case (br)
            3'b000:  f = (a == b);
            3'b001:  f = (a != b);
            3'b010:  f = ($signed(a) < $signed(b));
            3'b011:  f = ($signed(a) >= $signed(b));
            3'b100:  f = (a < b);
            3'b101:  f = (a >= b);
            default: f = 1'b0;
        endcase
        return {f, r};
    endfunction

    always_comb {AluBranch_i, AluResult_i} = alu_fn(AluSrcA_o, AluSrcB_o, AluCtrl_o, AluBranchCtrl_o);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        m_valid = 2'b00;
        m_last  = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    // One cycle: check grant and ALU drive, push expected, clock, pop and compare.
    task automatic drive_cycle(output logic [1:0] g);
        logic [1:0]  elig, expg;
        logic [32:0] got, exp;
        elig = ReqValid_i & (~m_valid | RspReady_i);
        expg = (elig == 2'b11) ? (m_last ? 2'b01 : 2'b10) : elig;
        #2;
        total++;
        if (ReqReady_o !== expg) begin
            bad++;
            $display("FAIL grant: got %b required %b", ReqReady_o, expg);
        end
        g = ReqReady_o;
        total++;
        if (expg[0]) begin
            if ({AluSrcA_o, AluSrcB_o, AluCtrl_o, AluBranchCtrl_o} !==
                {SrcA0_i, SrcB0_i, ALUctrl0_i, BranchCtrl0_i}) begin
                bad++;
                $display("FAIL alu_drive0: got %h/%h/%h/%h required %h/%h/%h/%h", AluSrcA_o, AluSrcB_o,
                         AluCtrl_o, AluBranchCtrl_o, SrcA0_i, SrcB0_i, ALUctrl0_i, BranchCtrl0_i);
            end
            q0.push_back(alu_fn(SrcA0_i, SrcB0_i, ALUctrl0_i, BranchCtrl0_i));
        end else if (expg[1]) begin
            if ({AluSrcA_o, AluSrcB_o, AluCtrl_o, AluBranchCtrl_o} !==
                {SrcA1_i, SrcB1_i, ALUctrl1_i, BranchCtrl1_i}) begin
                bad++;
                $display("FAIL alu_drive1: got %h/%h/%h/%h required %h/%h/%h/%h", AluSrcA_o, AluSrcB_o,
                         AluCtrl_o, AluBranchCtrl_o, SrcA1_i, SrcB1_i, ALUctrl1_i, BranchCtrl1_i);
            end
            q1.push_back(alu_fn(SrcA1_i, SrcB1_i, ALUctrl1_i, BranchCtrl1_i));
        end else begin
            if ({AluSrcA_o, AluSrcB_o, AluCtrl_o, AluBranchCtrl_o} !== {64'd0, 4'b0000, 3'b111}) begin
                bad++;
                $display("FAIL alu_idle: got %h/%h/%h/%h required 0/0/0/7", AluSrcA_o, AluSrcB_o,
                         AluCtrl_o, AluBranchCtrl_o);
            end
        end
        @(posedge clk_i); #1;
        for (int k = 0; k < 2; k++) m_valid[k] = expg[k] | (m_valid[k] & ~RspReady_i[k]);
        if (|expg) m_last = expg[1];
        total++;
        if (RspValid_o !== m_valid) begin
            bad++;
            $display("FAIL rsp_valid: got %b required %b", RspValid_o, m_valid);
        end
        if (expg[0] && q0.size() > 0) begin
            exp = q0.pop_front();
            got = {Branch0_o, Result0_o};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rsp0: got %h required %h", got, exp);
            end
        end
        if (expg[1] && q1.size() > 0) begin
            exp = q1.pop_front();
            got = {Branch1_o, Result1_o};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rsp1: got %h required %h", got, exp);
            end
        end
    endtask

    task automatic test_reset();
        ReqValid_i = 2'b11;
        RspReady_i = 2'b11;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        total++;
        if (ReqReady_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b required 00", ReqReady_o);
        end
        total++;
        if ({RspValid_o, Result0_o, Result1_o, Branch0_o, Branch1_o} !== 68'd0) begin
            bad++;
            $display("FAIL reset_state: got %b %h %h %b %b required all zero",
                     RspValid_o, Result0_o, Result1_o, Branch0_o, Branch1_o);
        end
        ReqValid_i = 2'b00;
        do_reset();
    endtask

    task automatic test_single();
        logic [1:0] g;
        SrcA0_i = 32'd5; SrcB0_i = 32'd3; ALUctrl0_i = ALU_ADD; BranchCtrl0_i = BR_BNONE;
        ReqValid_i = 2'b01; RspReady_i = 2'b00;
        drive_cycle(g);
        total++;
        if ({RspValid_o, Branch0_o, Result0_o} !== {2'b01, 1'b0, 32'd8}) begin
            bad++;
            $display("FAIL single_add: got %b %b %h required 01 0 00000008", RspValid_o, Branch0_o, Result0_o);
        end
        ReqValid_i = 2'b00; RspReady_i = 2'b01;
        drive_cycle(g);
    endtask

    task automatic test_alternate();
        logic [1:0] g;
        logic [1:0] seq [4];
        do_reset();
        SrcA0_i = 32'd10; SrcB0_i = 32'd4; ALUctrl0_i = ALU_SUB; BranchCtrl0_i = BR_BNONE;
        SrcA1_i = 32'hF0; SrcB1_i = 32'h0F; ALUctrl1_i = ALU_XOR; BranchCtrl1_i = BR_BNONE;
        ReqValid_i = 2'b11; RspReady_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(g);
            seq[i] = g;
        end
        total++;
        if ({seq[0], seq[1], seq[2], seq[3]} !== 8'b01_10_01_10) begin
            bad++;
            $display("FAIL alternate_order: got %b %b %b %b required 01 10 01 10", seq[0], seq[1], seq[2], seq[3]);
        end
        total++;
        if ({Result0_o, Result1_o} !== {32'd6, 32'hFF}) begin
            bad++;
            $display("FAIL alternate_results: got %h %h required 00000006 000000ff", Result0_o, Result1_o);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  g;
        logic [31:0] held;
        int          p1_grants;
        do_reset();
        SrcA0_i = 32'd1; SrcB0_i = 32'd1; ALUctrl0_i = ALU_ADD;
        SrcA1_i = 32'd7; SrcB1_i = 32'd2; ALUctrl1_i = ALU_SUB;
        ReqValid_i = 2'b11; RspReady_i = 2'b11;
        drive_cycle(g);
        RspReady_i = 2'b01;
        p1_grants = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(g);
            if (g[1]) p1_grants++;
            if (i == 0) begin
                held = Result1_o;
                SrcA1_i = 32'd100;
            end
            SrcA0_i = SrcA0_i + 32'd1;
        end
        total++;
        if (p1_grants != 1) begin
            bad++;
            $display("FAIL stall_grants: got %0d port1 grants required 1", p1_grants);
        end
        total++;
        if (Result1_o !== held || held !== 32'd5) begin
            bad++;
            $display("FAIL stall_hold: got %h (first %h) required 00000005", Result1_o, held);
        end
        RspReady_i = 2'b11;
        drive_cycle(g);
        total++;
        if (g !== 2'b10) begin
            bad++;
            $display("FAIL stall_release: got %b required 10", g);
        end
    endtask

    task automatic test_branch();
        logic [1:0] g;
        do_reset();
        SrcA1_i = 32'hFFFF_FFFF; SrcB1_i = 32'd1; ALUctrl1_i = ALU_ADD; BranchCtrl1_i = BR_BLT;
        ReqValid_i = 2'b10; RspReady_i = 2'b11;
        drive_cycle(g);
        total++;
        if (Branch1_o !== 1'b1) begin
            bad++;
            $display("FAIL branch_blt: got %b required 1", Branch1_o);
        end
        BranchCtrl1_i = BR_BLTU;
        drive_cycle(g);
        total++;
        if (Branch1_o !== 1'b0) begin
            bad++;
            $display("FAIL branch_bltu: got %b required 0", Branch1_o);
        end
    endtask

    task automatic test_drain_grant();
        logic [1:0] g;
        do_reset();
        SrcA0_i = 32'd1; SrcB0_i = 32'd2; ALUctrl0_i = ALU_ADD; BranchCtrl0_i = BR_BNONE;
        ReqValid_i = 2'b01; RspReady_i = 2'b01;
        drive_cycle(g);
        SrcA0_i = 32'd100; SrcB0_i = 32'd23;
        drive_cycle(g);
        total++;
        if ({RspValid_o[0], Result0_o} !== {1'b1, 32'd123}) begin
            bad++;
            $display("FAIL drain_grant: got %b %h required 1 0000007b", RspValid_o[0], Result0_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        do_reset();
        SrcA0_i = 32'd9; SrcB0_i = 32'd9; ALUctrl0_i = ALU_ADD; BranchCtrl0_i = BR_BEQ;
        SrcA1_i = 32'd3; SrcB1_i = 32'd4; ALUctrl1_i = ALU_OR;  BranchCtrl1_i = BR_BNE;
        ReqValid_i = 2'b11; RspReady_i = 2'b00;
        drive_cycle(g);
        drive_cycle(g);
        rst_i = 1'b1;
        #2;
        total++;
        if (ReqReady_o !== 2'b00) begin
            bad++;
            $display("FAIL midreset_ready: got %b required 00", ReqReady_o);
        end
        @(posedge clk_i); #1;
        total++;
        if ({RspValid_o, Result0_o, Result1_o, Branch0_o, Branch1_o} !== 68'd0) begin
            bad++;
            $display("FAIL midreset_state: got %b %h %h %b %b required all zero",
                     RspValid_o, Result0_o, Result1_o, Branch0_o, Branch1_o);
        end
        rst_i = 1'b0;
        m_valid = 2'b00; m_last = 1'b1;
        q0.delete(); q1.delete();
        RspReady_i = 2'b11;
        drive_cycle(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL midreset_tie: got %b required 01", g);
        end
    endtask

    initial begin
        m_valid = 2'b00;
        m_last  = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_branch();
        test_drain_grant();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle ALU between two requesters: port 0 is the main execute datapath, port 1 is the secondary address/compare user. Each port has a valid/ready request channel and a valid/ready response channel. The block grants at most one operation per cycle round-robin and drives the ALU operand and control inputs. It captures ALU result and branch flag into a per-port response register, which holds until drained.

## Interface
Parameters:
- DATAWIDTH, 32, operand/result width (matches ALU)
- CTRL_WIDTH, 4, ALU operation select width
- BR_WIDTH, 3, branch-compare select width

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- ReqValid_i  in  2  per-port request valid
- ReqReady_o  out  2  per-port request accepted this cycle
- SrcA0_i, SrcB0_i  in  DATAWIDTH each  port 0 operands
- SrcA1_i, SrcB1_i  in  DATAWIDTH each  port 1 operands
- ALUctrl0_i, ALUctrl1_i  in  CTRL_WIDTH  per-port ALU op
- BranchCtrl0_i, BranchCtrl1_i  in  BR_WIDTH  per-port branch compare
- RspValid_o  out  2  per-port response valid
- RspReady_i  in  2  per-port response consumed
- Result0_o, Result1_o  out  DATAWIDTH  registered ALU result per port
- Branch0_o, Branch1_o  out  1  registered branch flag per port
- AluSrcA_o, AluSrcB_o  out  DATAWIDTH  to ALU operands
- AluCtrl_o  out  CTRL_WIDTH  to ALU op select
- AluBranchCtrl_o  out  BR_WIDTH  to ALU branch select
- AluResult_i  in  DATAWIDTH  from ALU
- AluBranch_i  in  1  from ALU

## Operation
- Eligibility: port k eligible = ReqValid_i[k] & (!RspValid_o[k] | RspReady_i[k]). A full response slot blocks new grants to that port unless it drains in the same cycle.
- Arbitration: one eligible port is granted directly. If both are eligible, the port not equal to LastGrant is granted. LastGrant updates to the granted port on every grant and holds when no grant occurs.
- ReqReady_o = one-hot grant, or 0 when there is no grant. ReqReady_o may depend combinationally on ReqValid_i. Requesters must not make ReqValid_i depend on ReqReady_o.
- ALU drive: when a port is granted, its SrcA/SrcB/ALUctrl/BranchCtrl are muxed to the Alu*_o outputs. With no grant, outputs are 0, AluCtrl_o = 4'b0000 (add), AluBranchCtrl_o = 3'b111 (no-branch default).
- Capture: on a grant, AluResult_i and AluBranch_i are registered into that port's Result/Branch, and RspValid_o[k] is set.
- Drain: RspValid_o[k] & RspReady_i[k] with no new grant to k clears RspValid_o[k]. Result/Branch hold their last values.
- Simultaneous drain and grant on the same port: RspValid_o[k] stays 1 and the new data replaces the old.
- A request held while not granted must keep its operands stable. The block does not latch operands before the grant.
- The block passes through JAL/JALR branch semantics without decoding them: Branch is whatever the ALU reports.

## Timing
- Reset values: RspValid_o = 2'b00, Result0_o/Result1_o = 0, Branch0_o/Branch1_o = 0, LastGrant = 1 (port 0 wins the first tie), ReqReady_o = 0 while rst_i is high.
- Latency: a request accepted in cycle N gives RspValid_o high in cycle N+1 with the result.
- Throughput: 1 op/cycle total. With both ports continuously eligible, grants alternate 0,1,0,1.
- Backpressure: a port whose response is stalled (RspReady_i low) gets no grant, so the other port receives every cycle.
- Reset mid-operation: pending responses are discarded, LastGrant returns to 1, and no grant occurs in the reset cycle.
- The combinational path ReqValid_i→ReqReady_o/Alu*_o→AluResult_i→register is one cycle. No ALU pipelining is permitted.

## Structure
- Package alu_pkg: ALU op encodings (ADD=0000, SUB=0001 … JAL=1011, JALR=1100, LW=1111), branch encodings (BEQ=000 … BGEU=101, BNONE=111), NUM_REQ=2, and a typedef alu_req_t {srcA, srcB, ctrl, brctrl}.
- One sub-module, alu_rr_pick: inputs are the eligible vector and LastGrant; outputs are the one-hot grant and the granted index. It is combinational, and LastGrant is owned by alu_arbiter.
- The response registers and the operand mux stay in the top level.

## Test plan
- Reset, then port 0 only: SrcA=5, SrcB=3, ctrl ADD → ReqReady_o=01 same cycle; next cycle RspValid_o=01, Result0_o=8, Branch0_o=0.
- Both ports valid every cycle, RspReady_i=11: port 0 SUB 10-4, port 1 XOR F0^0F → grant order 0,1,0,1; Result0_o=6, Result1_o=FF.
- Port 1 response stalled (RspReady_i=01) while both request → port 1 granted once, then only port 0 granted until RspReady_i[1] rises; Result1_o holds.
- Branch path: port 1 BranchCtrl=BLT, SrcA=-1, SrcB=1 → Branch1_o=1 next cycle. BLTU with the same operands → Branch1_o=0.
- Same-cycle drain and grant on port 0 (RspValid_o[0]=1, RspReady_i[0]=1, new request) → RspValid_o[0] stays 1 and Result0_o updates to the new value.
- rst_i asserted with both responses pending → next cycle RspValid_o=00, Result=0, and the first tie afterwards goes to port 0.
